pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage, successor to the single-width PC register. Holds the architectural fetch PC and selects the next PC from sequential increment, PC-relative immediate target, ALU (register-indirect) target, or a return-address stack (RAS). It adds three things:
- target alignment checking with an error pulse;
- a configurable-depth circular RAS for call/return prediction;
- a configurable reset vector.

## Interface
- XLEN, 32, PC and target width
- RESET_VEC, 0, PC value loaded on reset (XLEN bits, 4-byte aligned)
- RAS_DEPTH, 4, RAS entries; power of two, at least 2

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  freeze PC and RAS for this cycle
- jump  in  1  redirect request
- jump_sel  in  2  target source: 0 pc4, 1 PC-relative immediate, 2 ALU, 3 RAS pop
- pc_imm  in  XLEN  PC-relative target
- alu_out  in  XLEN  register-indirect target
- ras_push  in  1  call: push pc4 onto RAS
- pc  out  XLEN  current fetch PC (registered)
- pc4  out  XLEN  pc + 4, combinational, modulo 2^XLEN
- misalign_err  out  1  registered one-cycle pulse: the previous cycle's redirect target was misaligned
- ras_empty  out  1  combinational; RAS count == 0
- ras_full  out  1  combinational; RAS count == RAS_DEPTH

## Operation
- Priority per cycle: rst > stall > jump > sequential.
- **stall=1**
  - pc, RAS contents, RAS pointer and RAS count all hold.
  - ras_push and the jump-driven pop are ignored.
  - misalign_err goes to 0.
- **jump=0** (not stalled): pc <= pc4.
- **jump=1** (not stalled): the target depends on jump_sel.
  - 0: pc4.
  - 1: pc_imm.
  - 2: {alu_out[XLEN-1:1], 1'b0}; bit 0 is cleared, JALR semantics.
  - 3: RAS top entry, and the top is popped. If the RAS is empty, the target is pc4 and count stays 0.
- **Alignment check**
  - A target with bits [1:0] != 0 after the bit-0 clear is misaligned.
  - On a misaligned target, pc holds and misalign_err = 1 in the next cycle.
  - A RAS pop still occurs in that cycle.
- **RAS storage**
  - Circular array with top pointer and count (0..RAS_DEPTH).
  - Push writes pc4 at top+1, advances top, and saturates count at RAS_DEPTH.
  - Pushing when full overwrites the oldest entry.
- **Simultaneous pop and push** in the same unstalled cycle: the pop reads the old top as the target, then pc4 is written into the same slot. Top pointer and count are unchanged.
- **Push without redirect**, or with jump_sel 0/1/2: push only.
- Wrap-around: pc4 at 0xFFFFFFFC (XLEN=32) is 0x00000000. There is no overflow flag.

## Timing
- **Reset** (asynchronous assert; release sampled at the next rising edge):
  - pc = RESET_VEC, pc4 = RESET_VEC+4;
  - RAS count 0 and top pointer 0, so ras_empty=1 and ras_full=0;
  - misalign_err = 0.
  - RAS data contents are don't-care.
- Reset asserted mid-operation clears all state immediately, regardless of stall or jump.
- Redirect latency is 1 cycle: the target is sampled at edge N and appears on pc after edge N.
- misalign_err asserts in the cycle after the offending request, lasts exactly one cycle, and is not sticky.
- ras_empty and ras_full reflect the count after the most recent edge.
- There is no combinational path from jump or targets to pc.

## Test plan
- **Reset and sequential fetch:** with RESET_VEC=0x100, release rst, 3 unstalled cycles -> pc = 0x100, 0x104, 0x108, 0x10C; misalign_err stays 0.
- **Stall versus redirect:** stall=1, jump=1, jump_sel=1, pc_imm=0x200 for 2 cycles -> pc holds. Then stall=0 -> pc=0x200 after 1 edge.
- **ALU target and misalignment:**
  - alu_out=0x305, jump_sel=2 -> pc=0x304.
  - alu_out=0x306 -> pc holds and misalign_err=1 for exactly the next cycle.
  - pc_imm=0x402, jump_sel=1 -> same hold and pulse behaviour.
- **Call and return:**
  - At pc=0x10, ras_push=1 with jump=1, jump_sel=1, pc_imm=0x80 -> pc=0x80, ras_empty=0.
  - Later, jump=1, jump_sel=3 -> pc=0x14, ras_empty=1.
- **RAS overflow and underflow** (RAS_DEPTH=4):
  - Push 5 times from pcs 0x0, 0x4, 0x8, 0xC, 0x10 -> ras_full=1; 4 pops return 0x14, 0x10, 0xC, 0x8.
  - A 5th pop -> pc = pc4, ras_empty=1.
- **Simultaneous pop and push, and wrap:**
  - With top=0x44 and pc=0x90, jump_sel=3 plus ras_push -> pc=0x44, new top=0x94, count unchanged.
  - At pc=0xFFFFFFFC with no jump -> pc=0x00000000.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program counter: selects the next PC from pc+4, a PC-relative
// target, an ALU target or a circular return-address stack, with alignment checking.
module pc_gen #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_VEC = '0,
   parameter int               RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            jump,
   input  logic [1:0]      jump_sel,
   input  logic [XLEN-1:0] pc_imm,
   input  logic [XLEN-1:0] alu_out,
   input  logic            ras_push,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4,
   output logic            misalign_err,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   localparam logic [1:0] SEL_PC4 = 2'd0;
   localparam logic [1:0] SEL_IMM = 2'd1;
   localparam logic [1:0] SEL_ALU = 2'd2;
   localparam logic [1:0] SEL_RAS = 2'd3;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            err_q, err_d;
   logic [PW-1:0]   top_q, top_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] ras_q [RAS_DEPTH];

   logic [XLEN-1:0] pc4_w;
   logic [XLEN-1:0] target;
   logic            misalign;
   logic            ras_nonempty;
   logic            pop_en;
   logic            push_en;
   logic [PW-1:0]   wr_idx;

   assign pc4_w        = pc_q + XLEN'(4);
   assign ras_nonempty = (cnt_q != '0);

   // Target mux; an empty-stack pop degrades to the sequential successor.
   always_comb begin
      target = pc4_w;
      unique case (jump_sel)
         SEL_PC4: target = pc4_w;
         SEL_IMM: target = pc_imm;
         SEL_ALU: target = alu_out & ~XLEN'(1);
         SEL_RAS: target = ras_nonempty ? ras_q[top_q] : pc4_w;
         default: target = pc4_w;
      endcase
   end

   assign misalign = (target[1:0] != 2'b00);
   assign pop_en   = !stall && jump && (jump_sel == SEL_RAS) && ras_nonempty;
   assign push_en  = !stall && ras_push;

   always_comb begin
      pc_d  = pc_q;
      err_d = 1'b0;
      if (!stall) begin
         if (!jump) begin
            pc_d = pc4_w;
         end else if (misalign) begin
            err_d = 1'b1;
         end else begin
            pc_d = target;
         end
      end
   end

   // Pop+push in one cycle replaces the top slot in place.
   always_comb begin
      top_d  = top_q;
      cnt_d  = cnt_q;
      wr_idx = top_q + PW'(1);
      if (pop_en && push_en) begin
         wr_idx = top_q;
      end else if (pop_en) begin
         top_d = top_q - PW'(1);
         cnt_d = cnt_q - CW'(1);
      end else if (push_en) begin
         top_d = top_q + PW'(1);
         if (cnt_q != CW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= RESET_VEC;
         err_q <= 1'b0;
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   // Stack data needs no reset; validity is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (push_en) begin
         ras_q[wr_idx] <= pc4_w;
      end
   end

   assign pc           = pc_q;
   assign pc4          = pc4_w;
   assign misalign_err = err_q;
   assign ras_empty    = (cnt_q == '0);
   assign ras_full     = (cnt_q == CW'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a queue-based reference model is compared against
// the DUT every cycle, alongside literal expectations for the scenarios.
module tb_pc_gen;

   localparam int          XLEN  = 32;
   localparam logic [31:0] RVEC  = 32'h100;
   localparam int          DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        jump;
   logic [1:0]  jump_sel;
   logic [31:0] pc_imm;
   logic [31:0] alu_out;
   logic        ras_push;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        misalign_err;
   logic        ras_empty;
   logic        ras_full;

   pc_gen #(.XLEN(XLEN), .RESET_VEC(RVEC), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_sel(jump_sel),
      .pc_imm(pc_imm), .alu_out(alu_out), .ras_push(ras_push),
      .pc(pc), .pc4(pc4), .misalign_err(misalign_err),
      .ras_empty(ras_empty), .ras_full(ras_full)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   // Reference model: PC as a number, the stack as a bounded queue.
   logic [31:0] m_pc;
   logic        m_err;
   logic [31:0] m_ras[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_pc  = RVEC;
      m_err = 1'b0;
      m_ras.delete();
   endfunction

   function automatic void model_step(bit s, bit j, logic [1:0] sel,
                                      logic [31:0] imm, logic [31:0] alu, bit push);
      logic [31:0] nxt;
      logic [31:0] tgt;
      bit          pop;
      nxt = m_pc + 32'd4;
      pop = 0;
      if (s) begin
         m_err = 1'b0;
         return;
      end
      tgt = nxt;
      if (j) begin
         case (sel)
            2'd1: tgt = imm;
            2'd2: tgt = {alu[31:1], 1'b0};
            2'd3: if (m_ras.size() > 0) begin tgt = m_ras[$]; pop = 1; end
            default: tgt = nxt;
         endcase
      end
      if (pop) void'(m_ras.pop_back());
      if (push) begin
         m_ras.push_back(nxt);
         if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (j && tgt[1:0] != 2'b00) begin
         m_err = 1'b1;
      end else begin
         m_pc  = tgt;
         m_err = 1'b0;
      end
   endfunction

   // Compare process: outputs settle well before posedge+2.
   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         check("pc", pc, m_pc);
         check("pc4", pc4, m_pc + 32'd4);
         check("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
         check("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
         check("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == DEPTH});
      end
   end

   task automatic step(bit s, bit j, logic [1:0] sel, logic [31:0] imm,
                       logic [31:0] alu, bit push);
      stall    = s;
      jump     = j;
      jump_sel = sel;
      pc_imm   = imm;
      alu_out  = alu;
      ras_push = push;
      @(posedge clk);
      #1;
      model_step(s, j, sel, imm, alu, push);
   endtask

   task automatic idle_inputs();
      stall = 0; jump = 0; jump_sel = 0; pc_imm = 0; alu_out = 0; ras_push = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check("reset_pc", pc, RVEC);
      check("reset_empty", {31'd0, ras_empty}, 32'd1);
      check("reset_full", {31'd0, ras_full}, 32'd0);
      check("reset_err", {31'd0, misalign_err}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      do_reset();
      chk_en = 1;

      // Sequential fetch from the reset vector.
      repeat (3) step(0, 0, 0, 0, 0, 0);
      check("seq_pc", pc, 32'h10C);
      check("seq_err", {31'd0, misalign_err}, 32'd0);

      // Stall beats a pending redirect, which then lands one edge later.
      repeat (2) step(1, 1, 1, 32'h200, 0, 0);
      check("stall_hold", pc, 32'h10C);
      step(0, 1, 1, 32'h200, 0, 0);
      check("redirect_imm", pc, 32'h200);

      // ALU target with bit 0 cleared, then misaligned targets.
      step(0, 1, 2, 0, 32'h305, 0);
      check("alu_target", pc, 32'h304);
      step(0, 1, 2, 0, 32'h306, 0);
      check("alu_misalign_hold", pc, 32'h304);
      check("alu_misalign_err", {31'd0, misalign_err}, 32'd1);
      step(0, 0, 0, 0, 0, 0);
      check("err_one_cycle", {31'd0, misalign_err}, 32'd0);
      check("after_misalign_pc", pc, 32'h308);
      step(0, 1, 1, 32'h402, 0, 0);
      check("imm_misalign_hold", pc, 32'h308);
      check("imm_misalign_err", {31'd0, misalign_err}, 32'd1);

      // Call from 0x10 and return to 0x14.
      step(0, 1, 1, 32'h10, 0, 0);
      step(0, 1, 1, 32'h80, 0, 1);
      check("call_pc", pc, 32'h80);
      check("call_nonempty", {31'd0, ras_empty}, 32'd0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0, 0);
      check("return_pc", pc, 32'h14);
      check("return_empty", {31'd0, ras_empty}, 32'd1);

      // Overflow: five pushes keep the newest four.
      step(0, 1, 1, 32'h0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0, 1);
      check("overflow_full", {31'd0, ras_full}, 32'd1);
      step(0, 1, 3, 0, 0, 0);
      check("pop1", pc, 32'h14);
      step(0, 1, 3, 0, 0, 0);
      check("pop2", pc, 32'h10);
      step(0, 1, 3, 0, 0, 0);
      check("pop3", pc, 32'hC);
      step(0, 1, 3, 0, 0, 0);
      check("pop4", pc, 32'h8);
      step(0, 1, 3, 0, 0, 0);
      check("underflow_pc", pc, 32'hC);
      check("underflow_empty", {31'd0, ras_empty}, 32'd1);

      // Simultaneous pop and push replaces the top.
      step(0, 1, 1, 32'h40, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 32'h90, 0, 0);
      step(0, 1, 3, 0, 0, 1);
      check("poppush_pc", pc, 32'h44);
      check("poppush_count", {30'd0, ras_empty, ras_full}, 32'd0);
      step(0, 1, 3, 0, 0, 0);
      check("poppush_newtop", pc, 32'h94);
      check("poppush_drained", {31'd0, ras_empty}, 32'd1);

      // Wrap at the top of the address space.
      step(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
      check("wrap_pc4", pc4, 32'h0);
      step(0, 0, 0, 0, 0, 0);
      check("wrap_pc", pc, 32'h0);

      // Stalled push is ignored.
      step(1, 0, 0, 0, 0, 1);
      check("stall_push_ignored", {31'd0, ras_empty}, 32'd1);

      // Mid-operation reset clears state immediately.
      step(0, 0, 0, 0, 0, 1);
      stall = 1; jump = 1; jump_sel = 2'd1; pc_imm = 32'h500; ras_push = 1;
      #2;
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      check("post_reset_pc", pc, 32'h104);

      @(negedge clk);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
